dmem_responder: RTL and testbench

Responder end of the core's data-memory load/store interface. It accepts one load or store request from the MEM stage, inserts a programmable number of wait states and applies RISC-V byte/halfword/word lane rules. It returns extended load data with a one-cycle completion pulse. While an access is outstanding it holds the pipeline through `stall`.

---
 rtl/dmem_pkg.sv | 36 +++
 rtl/dmem_lane_align.sv | 86 ++++++++
 rtl/dmem_responder.sv | 179 +++++++++++++++++
 tb/tb_dmem_responder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder: RISC-V load/store width
// codes (func3), the responder state encoding, width constants and a helper
// that classifies a func3 code as illegal for the access direction.
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam int XLEN   = 32;
    localparam int NBYTES = 4;
    localparam int WAIT_W = 3;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // Unsigned widths exist only for loads; 011/110/111 are never legal.
    function automatic logic f3_illegal(input logic [2:0] func3, input logic is_store);
        logic ill;
        case (func3)
            F3_B, F3_H, F3_W: ill = 1'b0;
            F3_BU, F3_HU:     ill = is_store;
            default:          ill = 1'b1;
        endcase
        return ill;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// -----------------------------------------------------------------------------
// dmem_lane_align
// Purely combinational byte-lane logic for a 32-bit little-endian data port.
//   addr_lo     : byte offset within the word (addr[1:0])
//   func3       : RISC-V width/sign code
//   store_data  : LSB-aligned store data
//   load_word   : full word read from the backing array
//   strb        : byte write strobes for a store
//   store_lanes : store data replicated across all lanes of its width
//   load_data   : selected and sign/zero-extended load result
//   misaligned  : halfword on odd address or word not on a word boundary
// -----------------------------------------------------------------------------
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] load_word,
    output logic [NBYTES-1:0] strb,
    output logic [XLEN-1:0] store_lanes,
    output logic [XLEN-1:0] load_data,
    output logic            misaligned
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed byte and halfword out of the loaded word.
    always_comb begin
        byte_s = 8'h00;
        case (addr_lo)
            2'd0:    byte_s = load_word[7:0];
            2'd1:    byte_s = load_word[15:8];
            2'd2:    byte_s = load_word[23:16];
            2'd3:    byte_s = load_word[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr_lo[1]) begin
            half_s = load_word[31:16];
        end else begin
            half_s = load_word[15:0];
        end
    end

    // Strobes, store replication, load extension and alignment per width code.
    always_comb begin
        strb        = 4'b0000;
        store_lanes = 32'h0000_0000;
        load_data   = 32'h0000_0000;
        misaligned  = 1'b0;
        case (func3)
            F3_B: begin
                strb        = 4'b0001 << addr_lo;
                store_lanes = {4{store_data[7:0]}};
                load_data   = {{24{byte_s[7]}}, byte_s};
            end
            F3_BU: begin
                load_data   = {24'h00_0000, byte_s};
            end
            F3_H: begin
                strb        = addr_lo[1] ? 4'b1100 : 4'b0011;
                store_lanes = {2{store_data[15:0]}};
                load_data   = {{16{half_s[15]}}, half_s};
                misaligned  = addr_lo[0];
            end
            F3_HU: begin
                load_data   = {16'h0000, half_s};
                misaligned  = addr_lo[0];
            end
            F3_W: begin
                strb        = 4'b1111;
                store_lanes = store_data;
                load_data   = load_word;
                misaligned  = |addr_lo;
            end
            default: begin
                strb        = 4'b0000;
                store_lanes = 32'h0000_0000;
                load_data   = 32'h0000_0000;
                misaligned  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Responder side of the core's data-memory interface. Accepts one load or
// store, waits WAIT_STATES cycles, then commits the store / returns the
// extended load data with a one-cycle rsp_valid pulse. stall holds the MEM
// stage from the request cycle until the response cycle.
//   clk, rst          : clock, asynchronous active-high reset
//   req_rd, req_wr    : load / store request (store wins if both)
//   req_addr          : byte address, word index = addr[31:2]
//   req_wdata         : LSB-aligned store data
//   req_func3         : RISC-V width/sign code
//   stall             : access accepted or pending, not yet completed
//   rsp_valid         : completion pulse
//   rsp_rdata         : extended load data (0 for stores and faults)
//   err               : fault flag, qualified by rsp_valid
// -----------------------------------------------------------------------------
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_rd,
    input  logic            req_wr,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [2:0]      req_func3,
    output logic            stall,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam bit HAS_WAIT = (WAIT_STATES > 0);
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        HAS_WAIT ? WAIT_W'(WAIT_STATES - 1) : {WAIT_W{1'b0}};

    dmem_state_t        state_r;
    logic [WAIT_W-1:0]  wait_cnt_r;
    logic [XLEN-1:0]    addr_r;
    logic [XLEN-1:0]    wdata_r;
    logic [2:0]         func3_r;
    logic               is_wr_r;
    logic               is_rd_r;

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    logic               req_s;
    logic [XLEN-1:0]    acc_addr_s;
    logic [XLEN-1:0]    acc_wdata_s;
    logic [2:0]         acc_func3_s;
    logic               acc_wr_s;
    logic               acc_rd_s;
    logic [IDX_W-1:0]   idx_s;
    logic               oor_s;
    logic               fault_s;
    logic               enter_resp_s;
    logic               we_s;
    logic [XLEN-1:0]    mem_word_s;
    logic [NBYTES-1:0]  strb_s;
    logic [XLEN-1:0]    lanes_s;
    logic [XLEN-1:0]    load_data_s;
    logic               misaligned_s;

    // Access operands: with zero wait states the commit edge is the accept
    // edge, so in IDLE the live request is used instead of the latched copy.
    always_comb begin
        req_s = req_rd | req_wr;
        if (state_r == IDLE) begin
            acc_addr_s  = req_addr;
            acc_wdata_s = req_wdata;
            acc_func3_s = req_func3;
            acc_wr_s    = req_wr;
            acc_rd_s    = req_rd & ~req_wr;
        end else begin
            acc_addr_s  = addr_r;
            acc_wdata_s = wdata_r;
            acc_func3_s = func3_r;
            acc_wr_s    = is_wr_r;
            acc_rd_s    = is_rd_r;
        end
    end

    dmem_lane_align u_lane_align (
        .addr_lo     (acc_addr_s[1:0]),
        .func3       (acc_func3_s),
        .store_data  (acc_wdata_s),
        .load_word   (mem_word_s),
        .strb        (strb_s),
        .store_lanes (lanes_s),
        .load_data   (load_data_s),
        .misaligned  (misaligned_s)
    );

    // Fault classification, array read port and commit-edge detection.
    always_comb begin
        idx_s        = acc_addr_s[IDX_W+1:2];
        oor_s        = ({2'b00, acc_addr_s[XLEN-1:2]} >= 32'(DEPTH_WORDS));
        fault_s      = oor_s | misaligned_s | f3_illegal(acc_func3_s, acc_wr_s);
        mem_word_s   = mem[idx_s];
        enter_resp_s = ((state_r == IDLE) && req_s && !HAS_WAIT) ||
                       ((state_r == WAIT) && (wait_cnt_r == WAIT_LAST));
        // Reset on the commit edge must drop the store.
        we_s         = enter_resp_s & acc_wr_s & ~fault_s & ~rst;
        stall        = ~rst & (((state_r == IDLE) & req_s) | (state_r == WAIT));
    end

    // Access FSM, wait counter, request latches and registered response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            wait_cnt_r <= {WAIT_W{1'b0}};
            addr_r     <= 32'h0000_0000;
            wdata_r    <= 32'h0000_0000;
            func3_r    <= 3'b000;
            is_wr_r    <= 1'b0;
            is_rd_r    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'h0000_0000;
            err        <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0000_0000;
            err       <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req_s) begin
                        addr_r     <= req_addr;
                        wdata_r    <= req_wdata;
                        func3_r    <= req_func3;
                        is_wr_r    <= req_wr;
                        is_rd_r    <= req_rd & ~req_wr;
                        wait_cnt_r <= {WAIT_W{1'b0}};
                        state_r    <= HAS_WAIT ? WAIT : RESP;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                WAIT: begin
                    if (wait_cnt_r == WAIT_LAST) begin
                        wait_cnt_r <= {WAIT_W{1'b0}};
                        state_r    <= RESP;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 3'd1;
                    end
                end
                RESP: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r    <= IDLE;
                    wait_cnt_r <= {WAIT_W{1'b0}};
                end
            endcase
            if (enter_resp_s) begin
                rsp_valid <= 1'b1;
                err       <= fault_s;
                rsp_rdata <= (acc_rd_s & ~fault_s) ? load_data_s : 32'h0000_0000;
            end else begin
                rsp_valid <= 1'b0;
            end
        end
    end

    // Backing array write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we_s) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (strb_s[i]) begin
                    mem[idx_s][8*i +: 8] <= lanes_s[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Two responder instances (2 wait states and 0 wait states) share one request
// bus, gated by a per-instance enable. Expected responses come from a
// byte-array model and are queued when a request is issued; a monitor pops
// and compares whenever an instance raises rsp_valid.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd = 1'b0, wr = 1'b0, en_a = 1'b0, en_b = 1'b0;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic [2:0]  f3 = 3'b000;

    logic        stall_a, valid_a, err_a, stall_b, valid_b, err_b;
    logic [31:0] rdata_a, rdata_b;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    logic [7:0] mem_m [2][4*DEPTH];

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(2)) u_dut_a (
        .clk(clk), .rst(rst),
        .req_rd(rd & en_a), .req_wr(wr & en_a),
        .req_addr(addr), .req_wdata(wdata), .req_func3(f3),
        .stall(stall_a), .rsp_valid(valid_a), .rsp_rdata(rdata_a), .err(err_a)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_dut_b (
        .clk(clk), .rst(rst),
        .req_rd(rd & en_b), .req_wr(wr & en_b),
        .req_addr(addr), .req_wdata(wdata), .req_func3(f3),
        .stall(stall_b), .rsp_valid(valid_b), .rsp_rdata(rdata_b), .err(err_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference: access is a run of bytes at addr, legal widths 1/2/4.
    function automatic void model(input int b, input bit w, input logic [31:0] a,
                                  input logic [31:0] d, input logic [2:0] f,
                                  output logic [31:0] res, output logic fault);
        int sz;
        logic [31:0] val;
        case (f)
            3'd0, 3'd4: sz = 1;
            3'd1, 3'd5: sz = 2;
            3'd2:       sz = 4;
            default:    sz = 0;
        endcase
        fault = (sz == 0) || (w && f[2]) || ((a % 32'(sz == 0 ? 1 : sz)) != 0) ||
                ((a >> 2) >= 32'(DEPTH));
        res = 32'h0;
        if (!fault) begin
            if (w) begin
                for (int i = 0; i < sz; i++) mem_m[b][a + 32'(i)] = d[8*i +: 8];
            end else begin
                val = 32'h0;
                for (int i = 0; i < sz; i++) val[8*i +: 8] = mem_m[b][a + 32'(i)];
                if (!f[2] && sz < 4 && val[8*sz-1]) val = val | ~((32'h1 << (8*sz)) - 32'h1);
                res = val;
            end
        end
    endfunction

    task automatic mon(input bit b, input logic [31:0] rv, input logic e);
        exp_t x;
        if ((b && q_b.size() == 0) || (!b && q_a.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL spurious_rsp dut%0d at cycle %0d: got rsp_valid=1, expected none", b, cyc);
        end else begin
            if (b) x = q_b.pop_front();
            else   x = q_a.pop_front();
            chk(b ? "latency_b" : "latency_a", 32'(cyc), 32'(x.cyc));
            chk(b ? "rdata_b" : "rdata_a", rv, x.rdata);
            chk(b ? "err_b" : "err_a", {31'h0, e}, {31'h0, x.err});
        end
    endtask

    // Response monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (valid_a === 1'b1) mon(1'b0, rdata_a, err_a);
        if (valid_b === 1'b1) mon(1'b1, rdata_b, err_b);
    end

    // One request, held for one cycle, with stall checked each cycle until RESP.
    task automatic issue(input bit b, input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] f);
        int   ws;
        exp_t e;
        ws = b ? 0 : 2;
        @(negedge clk);
        rd = r; wr = w; addr = a; wdata = d; f3 = f;
        en_a = !b; en_b = b;
        model(b ? 1 : 0, w, a, d, f, e.rdata, e.err);
        e.cyc = cyc + ws + 1;
        if (b) q_b.push_back(e);
        else   q_a.push_back(e);
        #1;
        chk("stall_req_cycle", {31'h0, b ? stall_b : stall_a}, 32'h1);
        @(negedge clk);
        rd = 1'b0; wr = 1'b0; en_a = 1'b0; en_b = 1'b0;
        for (int k = 1; k <= ws; k++) begin
            chk("stall_wait", {31'h0, stall_a}, 32'h1);
            @(negedge clk);
        end
        chk("stall_resp", {31'h0, b ? stall_b : stall_a}, 32'h0);
    endtask

    task automatic rand_op(input bit b);
        bit          w, r;
        int          word, kind;
        logic [31:0] a;
        w = 1'($urandom_range(0, 1));
        r = w ? 1'($urandom_range(0, 1)) : 1'b1;
        kind = $urandom_range(0, 9);
        if (kind == 0)            word = DEPTH + $urandom_range(0, 200);
        else if (kind == 1 && !b) word = 1020 + $urandom_range(0, 3);
        else                      word = $urandom_range(0, b ? 15 : 31);
        a = (32'(word) << 2) | 32'($urandom_range(0, 3));
        if (kind == 2) a = $urandom() | 32'h8000_0000;
        issue(b, r, w, a, $urandom(), 3'($urandom_range(0, 7)));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        // Reset state of both instances.
        @(negedge clk);
        @(negedge clk);
        chk("rst_stall_a", {31'h0, stall_a}, 32'h0);
        chk("rst_valid_a", {31'h0, valid_a}, 32'h0);
        chk("rst_rdata_a", rdata_a, 32'h0);
        chk("rst_err_a",   {31'h0, err_a}, 32'h0);
        chk("rst_stall_b", {31'h0, stall_b}, 32'h0);
        chk("rst_valid_b", {31'h0, valid_b}, 32'h0);
        rst = 1'b0;

        // Give every word that will ever be loaded a known value.
        for (int i = 0; i < 32; i++) issue(1'b0, 1'b0, 1'b1, 32'(i) << 2, $urandom(), 3'b010);
        for (int i = 1020; i < 1024; i++) issue(1'b0, 1'b0, 1'b1, 32'(i) << 2, $urandom(), 3'b010);
        for (int i = 0; i < 16; i++) issue(1'b1, 1'b0, 1'b1, 32'(i) << 2, $urandom(), 3'b010);

        // Word store/load, byte and halfword lanes with extension.
        issue(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010);
        issue(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010);
        issue(1'b0, 1'b0, 1'b1, 32'h11, 32'h000000F0, 3'b000);
        issue(1'b0, 1'b1, 1'b0, 32'h11, 32'h0, 3'b000);
        issue(1'b0, 1'b1, 1'b0, 32'h11, 32'h0, 3'b100);
        issue(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010);
        issue(1'b0, 1'b0, 1'b1, 32'h12, 32'h00008001, 3'b001);
        issue(1'b0, 1'b1, 1'b0, 32'h12, 32'h0, 3'b001);
        issue(1'b0, 1'b1, 1'b0, 32'h12, 32'h0, 3'b101);
        issue(1'b0, 1'b1, 1'b0, 32'h13, 32'h0, 3'b001);
        issue(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010);

        // Faults: misaligned, out of range, illegal unsigned store.
        issue(1'b0, 1'b0, 1'b1, 32'h1002, 32'hCAFEF00D, 3'b010);
        issue(1'b0, 1'b1, 1'b0, 32'(4 * DEPTH), 32'h0, 3'b010);
        issue(1'b0, 1'b0, 1'b1, 32'h12, 32'hCAFEF00D, 3'b010);
        issue(1'b0, 1'b0, 1'b1, 32'h14, 32'hCAFEF00D, 3'b100);
        issue(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010);
        issue(1'b0, 1'b1, 1'b0, 32'h14, 32'h0, 3'b010);
        issue(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 3'b010);

        // Reset during the wait states of a store: no response, no write.
        @(negedge clk);
        rd = 1'b0; wr = 1'b1; addr = 32'h20; wdata = 32'h12345678; f3 = 3'b010; en_a = 1'b1;
        @(negedge clk);
        wr = 1'b0; en_a = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_stall", {31'h0, stall_a}, 32'h0);
        chk("mid_rst_valid", {31'h0, valid_a}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        issue(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 3'b010);

        // Zero wait states, read and write together: store wins, back-to-back.
        issue(1'b1, 1'b1, 1'b1, 32'h30, 32'h00000055, 3'b010);
        issue(1'b1, 1'b1, 1'b0, 32'h30, 32'h0, 3'b010);
        issue(1'b1, 1'b1, 1'b0, 32'h31, 32'h0, 3'b000);

        // Randomized traffic on both instances.
        for (int n = 0; n < 150; n++) rand_op(1'b0);
        for (int n = 0; n < 80; n++) rand_op(1'b1);

        repeat (6) @(negedge clk);
        chk("pending_a", 32'(q_a.size()), 32'h0);
        chk("pending_b", 32'(q_b.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
